// File: rtl/fmap_seq_pkg.sv
// fmap_seq_pkg: data word width, frame geometry and read-pacing helper shared by the frame sequencer.
package fmap_seq_pkg;
  localparam int DATA_LEN = 16;
  localparam int FRAME_ROWS = 12;
  localparam int FRAME_COLS = 288;
  localparam int FRAME_WORDS = FRAME_ROWS * FRAME_COLS;
  // Words held or owed to the output FIFO once this cycle's pop has been taken.
  function automatic logic [2:0] occupancy(input logic [1:0] cnt, input logic inflight, input logic pop);
    return {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
  endfunction
endpackage

// File: rtl/fmap_seq_fifo2.sv
// fmap_seq_fifo2: two-entry valid/ready FIFO with registered storage, cleared on reset.
module fmap_seq_fifo2
  import fmap_seq_pkg::*;
#(
  parameter int W = DATA_LEN + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   cnt_o
);
  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         push, pop;
  assign push    = push_i && cnt_q != 2'd2;
  assign pop     = pop_i && cnt_q != 2'd0;
  assign valid_o = cnt_q != 2'd0;
  assign data_o  = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      cnt_q    <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/fmap_seq.sv
// fmap_seq: loads one frame into an external single-port RAM, then streams it back out in order.
module fmap_seq
  import fmap_seq_pkg::*;
#(
  parameter int DWIDTH = DATA_LEN,
  parameter int AWIDTH = 12,
  parameter int WORDS  = FRAME_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              full,
  input  logic              rd_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic              done,
  output logic              ram_load,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_d,
  input  logic [DWIDTH-1:0] ram_q
);
  typedef enum logic [1:0] {IDLE, WRITE, FULL, READ} state_t;
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(WORDS - 1);
  state_t            state_q;
  logic [AWIDTH-1:0] wr_addr_q, rd_addr_q;
  logic              rd_all_q, inflight_q, inflight_last_q, done_q;
  logic              fifo_valid, pop, rd_issue, wr_hs;
  logic [DWIDTH:0]   fifo_data;
  logic [1:0]        fifo_cnt;
  assign in_ready  = state_q == WRITE;
  assign full      = state_q == FULL;
  assign wr_hs     = in_valid && in_ready;
  assign ram_load  = wr_hs;
  assign ram_d     = in_data;
  assign ram_addr  = state_q == READ ? rd_addr_q : wr_addr_q;
  assign out_valid = fifo_valid;
  assign out_data  = fifo_data[DWIDTH-1:0];
  assign out_last  = fifo_valid && fifo_data[DWIDTH];
  assign done      = done_q;
  assign pop       = fifo_valid && out_ready;
  // Counting this cycle's pop as free lets reads issue back to back while the FIFO drains.
  assign rd_issue  = state_q == READ && !rd_all_q && occupancy(fifo_cnt, inflight_q, pop) < 3'd2;
  fmap_seq_fifo2 #(.W(DWIDTH + 1)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .data_i  ({inflight_last_q, ram_q}),
    .pop_i   (out_ready),
    .valid_o (fifo_valid),
    .data_o  (fifo_data),
    .cnt_o   (fifo_cnt)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      wr_addr_q       <= '0;
      rd_addr_q       <= '0;
      rd_all_q        <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      inflight_q      <= rd_issue;
      inflight_last_q <= rd_issue && rd_addr_q == LAST;
      done_q          <= pop && out_last;
      case (state_q)
        IDLE: if (wr_start) begin
          state_q   <= WRITE;
          wr_addr_q <= '0;
        end
        WRITE: if (wr_hs) begin
          if (wr_addr_q == LAST) state_q <= FULL;
          else wr_addr_q <= wr_addr_q + 1'b1;
        end
        FULL: if (rd_start) begin
          state_q   <= READ;
          rd_addr_q <= '0;
          rd_all_q  <= 1'b0;
        end
        READ: begin
          if (rd_issue) begin
            if (rd_addr_q == LAST) rd_all_q <= 1'b1;
            else rd_addr_q <= rd_addr_q + 1'b1;
          end
          if (pop && out_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fmap_seq.sv
// tb_fmap_seq: directed tests of an 8-word frame sequencer and one full default-size frame.
module tb_fmap_seq;
  int checks = 0;
  int failures = 0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wr_start = 0, in_valid = 0, rd_start = 0, out_ready = 0;
  logic [15:0] in_data = '0;
  logic        in_ready, full, out_valid, out_last, done, ram_load;
  logic [15:0] out_data, ram_d, ram_q;
  logic [2:0]  ram_addr;
  logic [15:0] mem8 [8];

  fmap_seq #(.DWIDTH(16), .AWIDTH(3), .WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_start(wr_start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .full(full), .rd_start(rd_start), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .done(done), .ram_load(ram_load), .ram_addr(ram_addr),
    .ram_d(ram_d), .ram_q(ram_q)
  );

  always @(posedge clk) begin
    if (ram_load) mem8[ram_addr] <= ram_d;
    ram_q <= mem8[ram_addr];
  end

  logic        b_wr_start = 0, b_in_valid = 0, b_rd_start = 0, b_out_ready = 0;
  logic [15:0] b_in_data = '0;
  logic        b_in_ready, b_full, b_out_valid, b_out_last, b_done, b_ram_load;
  logic [15:0] b_out_data, b_ram_d, b_ram_q;
  logic [11:0] b_ram_addr;
  logic [15:0] memb [4096];

  fmap_seq dut_big (
    .clk(clk), .rst_n(rst_n), .wr_start(b_wr_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .full(b_full), .rd_start(b_rd_start), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last), .done(b_done),
    .ram_load(b_ram_load), .ram_addr(b_ram_addr), .ram_d(b_ram_d), .ram_q(b_ram_q)
  );

  always @(posedge clk) begin
    if (b_ram_load) memb[b_ram_addr] <= b_ram_d;
    b_ram_q <= memb[b_ram_addr];
  end

  task automatic write_frame(input logic [15:0] base, input bit gaps, input int n, input bit hold_rd);
    int k, guard;
    k = 0;
    guard = 0;
    @(negedge clk);
    wr_start = 1;
    rd_start = hold_rd;
    @(negedge clk);
    wr_start = 0;
    while (k < n && guard < 200) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = base + 16'(k);
      #1;
      checks++;
      if (ram_load !== in_valid || (in_valid && ram_addr !== 3'(k))) begin
        failures++;
        $display("FAIL write_handshake k=%0d ram_load=%b ram_addr=%0d, required ram_load=%b ram_addr=%0d",
                 k, ram_load, ram_addr, in_valid, k);
      end
      if (in_valid) k++;
      guard++;
      @(negedge clk);
    end
    in_valid = 0;
    rd_start = 0;
    if (k < n) begin
      checks++;
      failures++;
      $display("FAIL write_timeout wrote %0d words, required %0d", k, n);
    end
  endtask

  task automatic read_frame(input logic [15:0] base, input bit stall, input bit hold_wr);
    int idx, c, first;
    logic [15:0] pd;
    logic pl, pstall;
    idx = 0;
    c = 0;
    first = -1;
    pstall = 0;
    pd = '0;
    pl = 0;
    @(negedge clk);
    rd_start = 1;
    wr_start = hold_wr;
    @(negedge clk);
    rd_start = 0;
    while (idx < 8 && c < 100) begin
      out_ready = stall ? ((c >= 6 && c < 11) ? 1'b0 : 1'(c % 2 == 0)) : 1'b1;
      #1;
      if (out_valid && first < 0) first = c;
      if (pstall) begin
        checks++;
        if (!out_valid || out_data !== pd || out_last !== pl) begin
          failures++;
          $display("FAIL stall_hold valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   out_valid, out_data, out_last, pd, pl);
        end
      end
      checks++;
      if (ram_load !== 1'b0 || int'(ram_addr) > idx + 2) begin
        failures++;
        $display("FAIL read_issue ram_load=%b ram_addr=%0d, required ram_load=0 ram_addr<=%0d",
                 ram_load, ram_addr, idx + 2);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== base + 16'(idx) || out_last !== (idx == 7)) begin
          failures++;
          $display("FAIL read_data idx=%0d data=%h last=%b, required data=%h last=%b",
                   idx, out_data, out_last, base + 16'(idx), idx == 7);
        end
        idx++;
      end
      pstall = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      c++;
      @(negedge clk);
    end
    wr_start = 0;
    if (idx < 8) begin
      checks++;
      failures++;
      $display("FAIL read_timeout read %0d words, required 8", idx);
    end
    if (!stall) begin
      checks++;
      if (first !== 2 || c !== 10) begin
        failures++;
        $display("FAIL read_latency first_valid_cycle=%0d end_cycle=%0d, required 2 and 10", first, c);
      end
    end
    checks++;
    if (done !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse done=%b full=%b out_valid=%b in_ready=%b, required 1 0 0 0",
               done, full, out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_single done=%b, required 0", done);
    end
  endtask

  task automatic check_full(input string name);
    checks++;
    if (full !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s full=%b in_ready=%b, required full=1 in_ready=0", name, full, in_ready);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({in_ready, out_valid, out_last, full, done, ram_load} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got %b, required 000000", {in_ready, out_valid, out_last, full, done, ram_load});
    end
    checks++;
    if (ram_addr !== 3'd0 || out_data !== 16'd0) begin
      failures++;
      $display("FAIL reset_buses ram_addr=%0d out_data=%h, required 0 0", ram_addr, out_data);
    end
    checks++;
    if ({b_full, b_out_valid, b_done, b_ram_load} !== 4'b0 || b_ram_addr !== 12'd0) begin
      failures++;
      $display("FAIL reset_big flags=%b ram_addr=%0d, required 0000 0", {b_full, b_out_valid, b_done, b_ram_load}, b_ram_addr);
    end
  endtask

  task automatic test_basic;
    write_frame(16'h0000, 0, 8, 0);
    check_full("basic_full");
    read_frame(16'h0000, 0, 0);
  endtask

  task automatic test_gaps;
    write_frame(16'h0040, 1, 8, 0);
    check_full("gaps_full");
    read_frame(16'h0040, 0, 0);
  endtask

  task automatic test_stall;
    write_frame(16'h0080, 0, 8, 0);
    check_full("stall_full");
    read_frame(16'h0080, 1, 0);
  endtask

  task automatic test_ignore;
    write_frame(16'h0a00, 0, 8, 1);
    check_full("ignore_full");
    in_valid = 1;
    in_data = 16'hdead;
    repeat (3) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || ram_load !== 1'b0 || full !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL full_ignores_input in_ready=%b ram_load=%b full=%b out_valid=%b, required 0 0 1 0",
                 in_ready, ram_load, full, out_valid);
      end
      @(negedge clk);
    end
    in_valid = 0;
    read_frame(16'h0a00, 0, 1);
  endtask

  task automatic test_reset_mid;
    write_frame(16'h0100, 0, 3, 0);
    in_valid = 1;
    in_data = 16'hbeef;
    rst_n = 0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_last, full, done, ram_load} !== 6'b0 || ram_addr !== 3'd0 || out_data !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid flags=%b ram_addr=%0d out_data=%h, required 000000 0 0",
               {in_ready, out_valid, out_last, full, done, ram_load}, ram_addr, out_data);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (mem8[0] !== 16'h0100 || ram_load !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_write mem0=%h ram_load=%b, required 0100 0", mem8[0], ram_load);
    end
    in_valid = 0;
    rst_n = 1;
    write_frame(16'h0200, 0, 8, 0);
    check_full("reset_mid_full");
    read_frame(16'h0200, 0, 0);
  endtask

  task automatic test_full_frame;
    int idx, c;
    @(negedge clk);
    b_wr_start = 1;
    @(negedge clk);
    b_wr_start = 0;
    b_in_valid = 1;
    for (int k = 0; k < 3456; k++) begin
      b_in_data = 16'(k * 7 + 3);
      #1;
      checks++;
      if (b_ram_load !== 1'b1 || b_ram_addr !== 12'(k)) begin
        failures++;
        $display("FAIL big_write k=%0d ram_load=%b ram_addr=%0d, required 1 %0d", k, b_ram_load, b_ram_addr, k);
      end
      @(negedge clk);
    end
    b_in_valid = 0;
    checks++;
    if (b_full !== 1'b1 || b_ram_addr !== 12'd3455) begin
      failures++;
      $display("FAIL big_full full=%b ram_addr=%0d, required 1 3455", b_full, b_ram_addr);
    end
    b_rd_start = 1;
    b_out_ready = 1;
    @(negedge clk);
    b_rd_start = 0;
    idx = 0;
    c = 0;
    while (idx < 3456 && c < 8000) begin
      #1;
      checks++;
      if (b_ram_addr > 12'd3455) begin
        failures++;
        $display("FAIL big_rd_addr ram_addr=%0d, required <=3455", b_ram_addr);
      end
      if (b_out_valid) begin
        checks++;
        if (b_out_data !== 16'(idx * 7 + 3) || b_out_last !== (idx == 3455)) begin
          failures++;
          $display("FAIL big_read idx=%0d data=%h last=%b, required %h %b",
                   idx, b_out_data, b_out_last, 16'(idx * 7 + 3), idx == 3455);
        end
        idx++;
      end
      c++;
      @(negedge clk);
    end
    checks++;
    if (idx !== 3456 || b_done !== 1'b1 || b_full !== 1'b0) begin
      failures++;
      $display("FAIL big_done words=%0d done=%b full=%b, required 3456 1 0", idx, b_done, b_full);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    @(negedge clk);
    rst_n = 1;
    test_basic;
    test_gaps;
    test_stall;
    test_ignore;
    test_reset_mid;
    test_full_frame;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
